alert_seq: RTL and testbench
============================

# alert_seq

Parametrised multi-pattern buzzer alert sequencer, successor to the single fixed-tone countdown alert.
- On a one-cycle trigger it plays one of four selectable patterns on the buzzer pin: single long tone, N short beeps, two-tone siren, or continuous tone.
- Tone square-wave generation and the millisecond timebase are internal.
- Sits between the countdown/timer control logic, which drives trigger, mode and stop, and the board buzzer pin.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- MS_DIV, 100_000, clock cycles per timebase tick (1 ms at 100 MHz).
- HZ_LO, 440, low tone frequency in Hz.
- HZ_HI, 880, high tone frequency in Hz.
- LONG_MS, 400, mode-0 tone length in ticks.
- BEEP_MS, 150, short beep / siren half-cycle length in ticks.
- GAP_MS, 100, silence between mode-1 beeps in ticks.
- CNT_W, 4, width of the beep-count input.
- DUR_W, 12, width of the tick duration counter; every *_MS parameter must be < 2^DUR_W.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- trigger  in  1  one-cycle start pulse; samples mode and beeps.
- mode  in  2  pattern select: 0 = long, 1 = N beeps, 2 = siren, 3 = continuous.
- beeps  in  CNT_W  mode-1 beep count; 0 is treated as 1.
- stop  in  1  abort the current pattern.
- buzzer  out  1  square-wave drive, registered.
- busy  out  1  high while a pattern is playing.
- done  out  1  one-cycle pulse when a finite pattern (mode 0 or 1) completes naturally.

## Operation
- Reset values: buzzer=0, busy=0, done=0, state=IDLE, all counters 0.
- Half-period constants are computed at elaboration with integer division:
  - HALF_LO = CLK_HZ/(2*HZ_LO)
  - HALF_HI = CLK_HZ/(2*HZ_HI)
  - Each must be ≥ 1.
- Timebase: prescaler counts 0..MS_DIV-1. A tick fires on the cycle it equals MS_DIV-1, then the prescaler wraps to 0. The prescaler is cleared on an accepted trigger and on every phase change.
- FSM states: IDLE, TONE, GAP.
- IDLE → TONE on trigger. Latch mode, and latch the beep counter as max(beeps,1). Tone selection: HI for modes 1 and 3; LO for modes 0 and 2.
- TONE: the phase lasts L ticks, where L = LONG_MS (mode 0) or BEEP_MS (modes 1, 2). Mode 3 has no limit. At the end of the phase:
  - mode 0 → IDLE with done.
  - mode 1, beeps remaining > 1 → decrement the count, go to GAP.
  - mode 1, last beep → IDLE with done.
  - mode 2 → stay in TONE with the tone swapped LO↔HI and the counters restarted.
- GAP: buzzer is held 0 for GAP_MS ticks, then → TONE (same tone).
- Tone generator: the half-period counter clears on TONE entry and on every tone swap. buzzer=1 on the first TONE cycle, then toggles each time the counter reaches HALF-1. buzzer is forced 0 in IDLE and GAP.
- busy = (state != IDLE).
- Retrigger while busy restarts the pattern from scratch with the newly sampled mode and beeps. No done pulse is issued for the aborted pattern.
- stop (any state) → IDLE next cycle, buzzer=0, no done pulse.
- stop and trigger in the same cycle: stop wins; the trigger is ignored.
- rst has priority over everything, including mid-pattern.
- Modes 2 and 3 end only via stop, retrigger or rst.

## Timing
- Trigger sampled at edge t: busy=1 and buzzer=1 from t+1.
- TONE phase length is exactly L*MS_DIV cycles. GAP is exactly GAP_MS*MS_DIV cycles.
- Mode 1 busy length is N*BEEP_MS*MS_DIV + (N-1)*GAP_MS*MS_DIV cycles. There is no trailing gap.
- done is asserted in the first IDLE cycle (busy=0 in the same cycle) for exactly one cycle.
- stop sampled at t: busy=0 and buzzer=0 at t+1.

## Test plan
Bench parameters for all scenarios: CLK_HZ=1000, MS_DIV=10, HZ_LO=100 (HALF=5), HZ_HI=250 (HALF=2), LONG_MS=5, BEEP_MS=3, GAP_MS=2.
- Mode 0 trigger at cycle 0 -> buzzer 1 on cycles 1–5, 0 on 6–10, alternating; busy for cycles 1–50; done=1 only at cycle 51; buzzer=0 from 51.
- Mode 1, beeps=3 -> three 30-cycle bursts toggling every 2 cycles, separated by two 20-cycle silent gaps; busy for 130 cycles; a single done pulse.
- Mode 1, beeps=0 -> identical to beeps=1: one 30-cycle burst, then done.
- Mode 2 -> 30 cycles at HALF=5, then 30 at HALF=2, alternating; after 200 cycles stop is pulsed -> buzzer=0 and busy=0 next cycle; done never asserts.
- Mode 0 running, retrigger with mode 1/beeps=2 at cycle 20 -> pattern restarts at cycle 21 with HI tone; 80 busy cycles follow; exactly one done pulse.
- stop and trigger asserted together in IDLE -> busy stays 0; rst asserted mid-GAP -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/alert_seq.sv
// Multi-pattern buzzer alert sequencer: long tone, N beeps, two-tone siren or
// continuous tone, with internal millisecond timebase and square-wave tone generator.
module alert_seq #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned MS_DIV  = 100_000,
  parameter int unsigned HZ_LO   = 440,
  parameter int unsigned HZ_HI   = 880,
  parameter int unsigned LONG_MS = 400,
  parameter int unsigned BEEP_MS = 150,
  parameter int unsigned GAP_MS  = 100,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DUR_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] beeps,
  input  logic             stop,
  output logic             buzzer,
  output logic             busy,
  output logic             done
);
  localparam int unsigned HALF_LO  = CLK_HZ / (2 * HZ_LO);
  localparam int unsigned HALF_HI  = CLK_HZ / (2 * HZ_HI);
  localparam int unsigned HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
  localparam int HW = $clog2(HALF_MAX + 1);
  localparam int PW = $clog2(MS_DIV + 1);

  localparam logic [HW-1:0]    HLO_M1   = HW'(HALF_LO - 1);
  localparam logic [HW-1:0]    HHI_M1   = HW'(HALF_HI - 1);
  localparam logic [PW-1:0]    PRE_END  = PW'(MS_DIV - 1);
  localparam logic [DUR_W-1:0] LONG_END = DUR_W'(LONG_MS - 1);
  localparam logic [DUR_W-1:0] BEEP_END = DUR_W'(BEEP_MS - 1);
  localparam logic [DUR_W-1:0] GAP_END  = DUR_W'(GAP_MS - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic             tone_hi;
  logic [PW-1:0]    pre;
  logic [DUR_W-1:0] dur;
  logic [HW-1:0]    hcnt;

  logic             tick, endless, ph_end;
  logic [DUR_W-1:0] ph_last;
  logic [HW-1:0]    half_m1;

  assign tick    = (pre == PRE_END);
  assign endless = (state == TONE) && (mode_q == 2'd3);
  assign half_m1 = tone_hi ? HHI_M1 : HLO_M1;
  assign busy    = (state != IDLE);

  always_comb begin
    ph_last = BEEP_END;
    if (state == GAP)          ph_last = GAP_END;
    else if (mode_q == 2'd0)   ph_last = LONG_END;
  end

  assign ph_end = tick && (dur == ph_last) && !endless;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= '0;
      cnt     <= '0;
      tone_hi <= 1'b0;
      pre     <= '0;
      dur     <= '0;
      hcnt    <= '0;
      buzzer  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // stop outranks a same-cycle trigger
        state  <= IDLE;
        buzzer <= 1'b0;
        cnt    <= '0;
        pre    <= '0;
        dur    <= '0;
        hcnt   <= '0;
      end else if (trigger) begin
        state   <= TONE;
        mode_q  <= mode;
        cnt     <= (beeps == '0) ? CNT_W'(1) : beeps;
        tone_hi <= mode[0];
        pre     <= '0;
        dur     <= '0;
        hcnt    <= '0;
        buzzer  <= 1'b1;
      end else if (state != IDLE) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick && !endless) dur <= dur + DUR_W'(1);
        if (state == TONE) begin
          if (hcnt == half_m1) begin
            hcnt   <= '0;
            buzzer <= ~buzzer;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        // phase boundary overrides the per-cycle counter updates above
        if (ph_end) begin
          pre  <= '0;
          dur  <= '0;
          hcnt <= '0;
          if (state == GAP) begin
            state  <= TONE;
            buzzer <= 1'b1;
          end else if (mode_q == 2'd2) begin
            tone_hi <= ~tone_hi;
            buzzer  <= 1'b1;
          end else if (mode_q == 2'd1 && cnt > CNT_W'(1)) begin
            cnt    <= cnt - CNT_W'(1);
            state  <= GAP;
            buzzer <= 1'b0;
          end else begin
            state  <= IDLE;
            buzzer <= 1'b0;
            done   <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alert_seq.sv
// Bench for alert_seq: waveform model from pattern offsets plus pinned literal points.
module tb_alert_seq;
  localparam int HLO = 5, HHI = 2, LONG_C = 50, BEEP_C = 30, GAP_C = 20;

  logic       clk = 1'b0, rst = 1'b1, trigger = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] beeps = 4'd0;
  logic       buzzer, busy, done;

  alert_seq #(
    .CLK_HZ(1000), .MS_DIV(10), .HZ_LO(100), .HZ_HI(250),
    .LONG_MS(5), .BEEP_MS(3), .GAP_MS(2), .CNT_W(4), .DUR_W(12)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .mode(mode), .beeps(beeps),
    .stop(stop), .buzzer(buzzer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // pattern tracker: offset o counts cycles since the accepted trigger
  int cyc = 0, o = 0, mm = 0, nn = 1;
  bit act = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || stop) begin
      act <= 1'b0;
      o   <= 0;
    end else if (trigger) begin
      act <= 1'b1;
      o   <= 1;
      mm  <= int'(mode);
      nn  <= (beeps == 4'd0) ? 1 : int'(beeps);
    end else if (act) begin
      o <= o + 1;
    end
  end

  function automatic void model_out(input bit a, input int m, input int n, input int off,
                                    output bit b, output bit z, output bit d);
    int tot, seg;
    b = 1'b0; z = 1'b0; d = 1'b0;
    if (!a) return;
    case (m)
      0: begin
        if (off <= LONG_C) begin b = 1'b1; z = (((off - 1) / HLO) % 2) == 0; end
        else d = (off == LONG_C + 1);
      end
      1: begin
        tot = n * BEEP_C + (n - 1) * GAP_C;
        if (off <= tot) begin
          b = 1'b1;
          seg = (off - 1) % (BEEP_C + GAP_C);
          z = (seg < BEEP_C) && (((seg / HHI) % 2) == 0);
        end else d = (off == tot + 1);
      end
      2: begin
        b = 1'b1;
        seg = (off - 1) % (2 * BEEP_C);
        if (seg < BEEP_C) z = ((seg / HLO) % 2) == 0;
        else              z = (((seg - BEEP_C) / HHI) % 2) == 0;
      end
      default: begin
        b = 1'b1;
        z = (((off - 1) / HHI) % 2) == 0;
      end
    endcase
  endfunction

  typedef struct {int c; bit b; bit z; bit d;} lit_t;
  lit_t lits[64];
  int   lit_n = 0;
  task automatic lit(input int c, input bit b, input bit z, input bit d);
    lits[lit_n] = '{c, b, z, d};
    lit_n++;
  endtask

  int n_chk = 0, n_fail = 0, li = 0;
  bit chk_en = 1'b0, fin = 1'b0;

  task automatic chk(input string name, input bit got, input bit exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit eb, ez, ed;
    if (chk_en) begin
      model_out(act, mm, nn, o, eb, ez, ed);
      chk("busy", busy, eb);
      chk("buzzer", buzzer, ez);
      chk("done", done, ed);
      while (li < lit_n && lits[li].c <= cyc) begin
        if (lits[li].c < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL lit%0d skipped: at cycle %0d, required cycle %0d", li, cyc, lits[li].c);
        end else begin
          chk("lit_busy", busy, lits[li].b);
          chk("lit_buzzer", buzzer, lits[li].z);
          chk("lit_done", done, lits[li].d);
        end
        li++;
      end
      if (fin && li < lit_n) begin
        n_chk++; n_fail++;
        $display("FAIL lit_pending: %0d checked, required %0d", li, lit_n);
        li = lit_n;
      end
    end
  end

  task automatic trig(input logic [1:0] m, input logic [3:0] n);
    mode = m; beeps = n; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    lit(1, 0, 0, 0);
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // mode 0: long LO tone
    b = cyc;
    lit(b+1, 1, 1, 0); lit(b+5, 1, 1, 0); lit(b+6, 1, 0, 0);
    lit(b+50, 1, 0, 0); lit(b+51, 0, 0, 1); lit(b+52, 0, 0, 0);
    trig(2'd0, 4'd0); goto(b+60);

    // mode 1, three beeps
    b = cyc;
    lit(b+1, 1, 1, 0); lit(b+3, 1, 0, 0); lit(b+31, 1, 0, 0);
    lit(b+51, 1, 1, 0); lit(b+130, 1, 1, 0); lit(b+131, 0, 0, 1);
    trig(2'd1, 4'd3); goto(b+140);

    // mode 1, beeps=0 acts as one beep
    b = cyc;
    lit(b+30, 1, 1, 0); lit(b+31, 0, 0, 1);
    trig(2'd1, 4'd0); goto(b+40);

    // mode 2 siren, then stop
    b = cyc;
    lit(b+1, 1, 1, 0); lit(b+6, 1, 0, 0); lit(b+31, 1, 1, 0);
    lit(b+33, 1, 0, 0); lit(b+61, 1, 1, 0); lit(b+66, 1, 0, 0);
    trig(2'd2, 4'd0); goto(b+200);
    lit(b+201, 0, 0, 0);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    goto(cyc+5);

    // retrigger mode 0 -> mode 1 / 2 beeps
    b = cyc;
    lit(b+20, 1, 0, 0); lit(b+21, 1, 1, 0); lit(b+23, 1, 0, 0);
    lit(b+100, 1, 1, 0); lit(b+101, 0, 0, 1); lit(b+102, 0, 0, 0);
    trig(2'd0, 4'd0); goto(b+20);
    trig(2'd1, 4'd2); goto(b+110);

    // stop and trigger together in IDLE
    b = cyc;
    lit(b+1, 0, 0, 0); lit(b+2, 0, 0, 0);
    mode = 2'd0; trigger = 1'b1; stop = 1'b1;
    @(negedge clk);
    trigger = 1'b0; stop = 1'b0;
    goto(b+5);

    // rst in the middle of a gap
    b = cyc;
    lit(b+35, 1, 0, 0); lit(b+41, 0, 0, 0); lit(b+42, 0, 0, 0);
    trig(2'd1, 4'd2); goto(b+40);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    goto(b+50);

    // mode 3 continuous, then stop
    b = cyc;
    lit(b+1, 1, 1, 0); lit(b+3, 1, 0, 0); lit(b+5, 1, 1, 0);
    trig(2'd3, 4'd5); goto(b+45);
    lit(cyc+1, 0, 0, 0);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    goto(cyc+3);

    fin = 1'b1;
    @(negedge clk); @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
